// File: rtl/byte_rr_arbiter.sv
// byte_rr_arbiter: 4-channel round-robin byte arbiter, 1-entry buffer per lane.
// Optional grant lock via BYTE_RR_ARB_HOLD_EN (adds hold_i).
module byte_rr_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  input  logic [3:0]        in_valid,
  output logic [3:0]        in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sel,
  output logic              out_valid,
  input  logic              out_ready
`ifdef BYTE_RR_ARB_HOLD_EN
  ,
  input  logic              hold_i
`endif
);

  logic [DATA_W-1:0] in_bytes [4];
  logic [DATA_W-1:0] buf_data [4];
  logic [3:0]        buf_valid;
  logic [1:0]        ptr;

  logic       loadable;
  logic       gnt_any;
  logic [1:0] gnt_idx;
  logic       hold_hit;
  logic [3:0] grant;

  assign in_bytes[0] = in_data0;
  assign in_bytes[1] = in_data1;
  assign in_bytes[2] = in_data2;
  assign in_bytes[3] = in_data3;

  assign loadable = ~out_valid | out_ready;

`ifdef BYTE_RR_ARB_HOLD_EN
  assign hold_hit = hold_i & buf_valid[out_sel];
`else
  assign hold_hit = 1'b0;
`endif

  // Descending scan so the lowest offset from ptr wins.
  always_comb begin
    logic [1:0] idx;
    gnt_any = 1'b0;
    gnt_idx = ptr;
    idx     = ptr;
    for (int o = 3; o >= 0; o--) begin
      idx = ptr + 2'(o);
      if (buf_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (hold_hit) begin
      gnt_any = 1'b1;
      gnt_idx = out_sel;
    end
  end

  always_comb begin
    grant = 4'b0000;
    if (loadable && gnt_any)
      grant[gnt_idx] = 1'b1;
  end

  assign in_ready = ~buf_valid | grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++)
        buf_data[i] <= '0;
      buf_valid <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          buf_data[i]  <= in_bytes[i];
          buf_valid[i] <= 1'b1;
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_sel   <= 2'd0;
      out_valid <= 1'b0;
      ptr       <= 2'd0;
    end else if (loadable) begin
      if (gnt_any) begin
        out_data  <= buf_data[gnt_idx];
        out_sel   <= gnt_idx;
        out_valid <= 1'b1;
        if (!hold_hit)
          ptr <= gnt_idx + 2'd1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_byte_rr_arbiter.sv
// tb_byte_rr_arbiter: random + directed bench against a queue-based model.
// Hold-lock scenarios run only when BYTE_RR_ARB_HOLD_EN is defined.
module tb_byte_rr_arbiter;

`ifdef BYTE_RR_ARB_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d [4];
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic       out_valid;
  logic       out_ready;
  logic       hold_i;

  int n_cmp = 0;
  int n_bad = 0;

  byte unsigned mq [4][$];
  int           mptr;
  bit           mov;
  logic [7:0]   mod;
  logic [1:0]   mos;

  always #5 clk = ~clk;

  byte_rr_arbiter #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data0 (d[0]),
    .in_data1 (d[1]),
    .in_data2 (d[2]),
    .in_data3 (d[3]),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef BYTE_RR_ARB_HOLD_EN
    ,
    .hold_i   (hold_i)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mq[i].delete();
    mptr = 0;
    mov  = 1'b0;
    mod  = 8'h00;
    mos  = 2'd0;
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_ov"}, 32'(out_valid), 32'(mov));
    chk({tag, "_od"}, 32'(out_data), 32'(mod));
    chk({tag, "_os"}, 32'(out_sel), 32'(mos));
  endtask

  // Called right after a negedge; returns right after the next negedge.
  task automatic cycle(input logic [3:0] v,
                       input logic ordy,
                       input logic hld);
    int k;
    bit ld;
    bit held;
    logic [3:0] er;
    in_valid  = v;
    out_ready = ordy;
    hold_i    = hld;
    #1;
    ld   = !mov || ordy;
    k    = -1;
    held = 1'b0;
    if (ld) begin
      if (HOLD && hld && mq[mos].size() > 0) begin
        k    = int'(mos);
        held = 1'b1;
      end else begin
        for (int o = 0; o < 4; o++)
          if (k < 0 && mq[(mptr + o) % 4].size() > 0)
            k = (mptr + o) % 4;
      end
    end
    er = 4'b0000;
    for (int i = 0; i < 4; i++)
      er[i] = (mq[i].size() == 0) || (k == i);
    chk("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    if (ld) begin
      if (k >= 0) begin
        mod = mq[k].pop_front();
        mos = 2'(k);
        mov = 1'b1;
        if (!held) mptr = (k + 1) % 4;
      end else begin
        mov = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++)
      if (v[i] && er[i]) mq[i].push_back(d[i]);
    @(negedge clk);
    chk_out("cyc");
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_ov", 32'(out_valid), 32'h0);
    chk("rst_os", 32'(out_sel), 32'h0);
    chk("rst_od", 32'(out_data), 32'h00);
    chk("rst_rdy", 32'(in_ready), 32'hF);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic setd(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] e);
    d[0] = a; d[1] = b; d[2] = c; d[3] = e;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 4'h0;
    out_ready = 1'b0;
    hold_i = 1'b0;
    setd(8'h00, 8'h00, 8'h00, 8'h00);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_out("init");
    chk("init_rdy", 32'(in_ready), 32'hF);
    rst_n = 1'b1;

    // Single channel streaming on ch2.
    setd(8'h00, 8'h00, 8'h11, 8'h00);
    cycle(4'b0100, 1'b1, 1'b0);
    chk("s_ov0", 32'(out_valid), 32'h0);
    d[2] = 8'h22;
    cycle(4'b0100, 1'b1, 1'b0);
    chk("s_d0", 32'(out_data), 32'h11);
    chk("s_sel0", 32'(out_sel), 32'h2);
    d[2] = 8'h33;
    cycle(4'b0100, 1'b1, 1'b0);
    chk("s_d1", 32'(out_data), 32'h22);
    cycle(4'b0000, 1'b1, 1'b0);
    chk("s_d2", 32'(out_data), 32'h33);
    chk("s_sel2", 32'(out_sel), 32'h2);
    cycle(4'b0000, 1'b1, 1'b0);
    chk("s_idle", 32'(out_valid), 32'h0);

    // Round robin over all four buffered channels.
    do_reset();
    setd(8'hA0, 8'hB1, 8'hC2, 8'hD3);
    cycle(4'b1111, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);
    chk("rr_a0", 32'(out_data), 32'hA0);
    cycle(4'b0000, 1'b1, 1'b0);
    chk("rr_b1", 32'(out_data), 32'hB1);
    cycle(4'b0000, 1'b1, 1'b0);
    chk("rr_c2", 32'(out_data), 32'hC2);
    cycle(4'b0000, 1'b1, 1'b0);
    chk("rr_d3", 32'(out_data), 32'hD3);
    chk("rr_s3", 32'(out_sel), 32'h3);
    setd(8'hE0, 8'h00, 8'h00, 8'hE3);
    cycle(4'b1001, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);
    chk("rr_e0", 32'(out_sel), 32'h0);
    cycle(4'b0000, 1'b1, 1'b0);
    chk("rr_e3", 32'(out_sel), 32'h3);
    chk("rr_e3d", 32'(out_data), 32'hE3);

    // Backpressure hold with a full ch1 buffer.
    do_reset();
    setd(8'h00, 8'h5A, 8'h00, 8'h00);
    cycle(4'b0010, 1'b0, 1'b0);
    d[1] = 8'h6B;
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0010, 1'b0, 1'b0);
      chk("bp_d", 32'(out_data), 32'h5A);
      chk("bp_s", 32'(out_sel), 32'h1);
    end
    chk("bp_rdy1", 32'(in_ready[1]), 32'h0);
    cycle(4'b0000, 1'b1, 1'b0);
    chk("bp_6b", 32'(out_data), 32'h6B);
    cycle(4'b0000, 1'b1, 1'b0);

    // ch3 granted while refilling, ch0-2 arriving.
    do_reset();
    setd(8'h00, 8'h00, 8'h00, 8'h3C);
    cycle(4'b1000, 1'b0, 1'b0);
    setd(8'h10, 8'h20, 8'h30, 8'h7E);
    cycle(4'b1111, 1'b1, 1'b0);
    chk("wr_3c", 32'(out_data), 32'h3C);
    for (int i = 0; i < 4; i++)
      cycle(4'b0000, 1'b1, 1'b0);
    chk("wr_7e", 32'(out_data), 32'h7E);
    chk("wr_s3", 32'(out_sel), 32'h3);

`ifdef BYTE_RR_ARB_HOLD_EN
    do_reset();
    setd(8'hAA, 8'h01, 8'h00, 8'h00);
    cycle(4'b0010, 1'b1, 1'b1);
    d[1] = 8'h02;
    cycle(4'b0011, 1'b1, 1'b1);
    d[1] = 8'h03;
    cycle(4'b0010, 1'b1, 1'b1);
    d[1] = 8'h04;
    cycle(4'b0010, 1'b1, 1'b1);
    cycle(4'b0000, 1'b1, 1'b1);
    chk("hd_04", 32'(out_data), 32'h04);
    chk("hd_s1", 32'(out_sel), 32'h1);
    cycle(4'b0000, 1'b1, 1'b0);
    chk("hd_ch0", 32'(out_sel), 32'h0);
`endif

    // Random traffic, with one mid-stream reset.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      if (n == 1500) do_reset();
      cycle(4'($urandom),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/byte_rr_arbiter.md
BYTE_RR_ARBITER -- requirements
Module: byte_rr_arbiter

Interface
REQ-001 Parameter: DATA_W, default 8, byte-lane width of every data port.
REQ-002 clk  input  1  single clock; all state rising-edge triggered.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_data0..in_data3  input  DATA_W  per-channel source bytes.
REQ-005 in_valid  input  4  bit i = channel i byte offered.
REQ-006 in_ready  output  4  bit i = channel i byte accepted this cycle when in_valid[i] also high.
REQ-007 out_data  output  DATA_W  registered granted byte.
REQ-008 out_sel  output  2  channel index of out_data; also drives the downstream 4:1 byte mux select.
REQ-009 out_valid  output  1  out_data/out_sel hold a valid transfer.
REQ-010 out_ready  input  1  downstream accepts the current transfer.
REQ-011 hold_i  input  1  grant lock request; present only with BYTE_RR_ARB_HOLD_EN.

Function
REQ-012 Each channel SHALL have one 1-entry buffer (buf_data[i], buf_valid[i]).
REQ-013 Output stage "loadable" SHALL be: ~out_valid | out_ready.
REQ-014 Grant SHALL be taken when loadable and any buf_valid set: first set buf_valid[k], scanning ptr, ptr+1, ... mod 4.
REQ-015 On grant k at a clock edge: out_data<=buf_data[k], out_sel<=k, out_valid<=1, buf_valid[k]<=0, ptr<=(k+1) mod 4.
REQ-016 Loadable with no buf_valid set: out_valid<=0; out_data/out_sel hold; ptr holds.
REQ-017 Not loadable (out_valid & ~out_ready): out_data, out_sel, out_valid, ptr SHALL hold unchanged.
REQ-018 in_ready[i] SHALL be ~buf_valid[i] | grant[i] (combinational), so a channel refills in the cycle its byte is granted.
REQ-019 in_valid[i] & in_ready[i] SHALL load buf_data[i]<=in_data_i, buf_valid[i]<=1; simultaneous grant and refill of the same channel SHALL leave buf_valid[i]=1 with the new byte.
REQ-020 Latency: byte accepted at edge N SHALL appear on out_valid after edge N+1 if uncontended and loadable; a single channel streaming with out_ready=1 SHALL achieve 1 byte/cycle.
REQ-021 ptr wrap: k=3 granted -> ptr=0.
REQ-022 No byte SHALL be dropped or duplicated; per-channel order preserved.
REQ-023 Starvation bound: a buffered channel SHALL be granted within 4 grants (without hold).

Reset
REQ-024 rst_n low SHALL asynchronously force: buf_valid=0, buf_data=0, out_valid=0, out_data=0, out_sel=0, ptr=0; in_ready=4'b1111 during/after reset.
REQ-025 Reset mid-transfer SHALL discard all buffered and output bytes; first grant after release SHALL scan from channel 0.
REQ-026 Reset release SHALL need no synchroniser inside the block; deassertion assumed synchronous to clk by the top level.

Configuration
REQ-027 Macro BYTE_RR_ARB_HOLD_EN defined: port hold_i exists; when hold_i=1, loadable and buf_valid[out_sel]=1, grant SHALL go to out_sel again and ptr SHALL not change; if buf_valid[out_sel]=0 normal round-robin applies.
REQ-028 Macro BYTE_RR_ARB_HOLD_EN undefined: hold_i port absent; behaviour exactly REQ-014..REQ-023.

Verification
REQ-029 Reset: rst_n=0 mid-stream -> out_valid=0, out_sel=0, out_data=8'h00, in_ready=4'hF immediately (no clock edge).
REQ-030 Single channel: ch2 sends 8'h11,8'h22,8'h33 back-to-back, out_ready=1 -> out_data 11,22,33 on 3 consecutive cycles, out_sel=2, first 2 edges after first accept.
REQ-031 Round-robin: all 4 channels buffered (A0,B1,C2,D3), ptr=0 -> outputs A0,B1,C2,D3 with out_sel 0,1,2,3; then ch0 and ch3 re-buffered -> ch0 then ch3.
REQ-032 Backpressure: out_ready=0 for 5 cycles with out_data=8'h5A, out_sel=1 -> both held stable, in_ready[1] stays 0 after buffer fills, no loss after out_ready=1.
REQ-033 Wrap/refill: ch3 granted while in_valid[3]=1 carrying 8'h7E -> ptr=0, buf_valid[3]=1 with 8'h7E, granted next only after channels 0-2 if they are pending.
REQ-034 HOLD_EN build: ch1 streaming 8'h01..8'h04, ch0 pending, hold_i=1 -> out_sel=1 for all four bytes, ch0 granted only after hold_i=0.
